// File: rtl/conv_ctrl_30_9_11_1.sv
// Sequencer for the 1-D convolution layer: buffers x, steps the tap MAC, hands out y.
// Optional macro CONV_CTRL_OVERLAP_EN: accept the next vector while the last y is held.
module conv_ctrl_30_9_11_1 #(
  parameter int N  = 30,
  parameter int M  = 9,
  parameter int AX = $clog2(N),
  parameter int AF = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid_x,
  output logic          s_ready_x,
  output logic          m_valid_y,
  input  logic          m_ready_y,
  output logic          wr_en_x,
  output logic [AX-1:0] addr_x,
  output logic [AF-1:0] addr_f,
  output logic          en_acc,
  output logic          clear_acc,
  output logic          load_out
);

  // state   | meaning
  // LOAD    | accepting input samples into x memory at ld
  // COMPUTE | issuing one x/f read per cycle for position i, tap k
  // DRAIN   | last read in flight through memory and MAC
  // OUT     | waiting for load_out / y handshake
  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUT} state_t;

  localparam logic [AX-1:0] LD_LAST  = AX'(N - 1);
  localparam logic [AX-1:0] POS_LAST = AX'(N - M);
  localparam logic [AF-1:0] TAP_LAST = AF'(M - 1);

  state_t        state, state_nxt;
  logic [AX-1:0] ld, pos;
  logic [AF-1:0] tap;
  logic          issue, last_d1, in_hs, y_hs;
`ifdef CONV_CTRL_OVERLAP_EN
  logic          x_full;
`endif

  always_comb begin
    s_ready_x = (state == LOAD);
`ifdef CONV_CTRL_OVERLAP_EN
    // All reads of the current vector are done once the last position reaches OUT.
    if (state == OUT && pos == POS_LAST && !x_full) s_ready_x = 1'b1;
`endif
  end

  assign in_hs   = s_valid_x & s_ready_x;
  assign wr_en_x = in_hs;
  assign y_hs    = m_valid_y & m_ready_y;

  always_ff @(posedge clk) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    addr_x    = '0;
    addr_f    = '0;
    case (state)
      LOAD: begin
        addr_x = ld;
        if (in_hs && ld == LD_LAST) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        issue  = 1'b1;
        addr_x = pos + AX'(tap);
        addr_f = tap;
        if (tap == TAP_LAST) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = OUT;
      OUT: begin
        if (s_ready_x) addr_x = ld;
        if (y_hs) begin
          if (pos != POS_LAST) state_nxt = COMPUTE;
`ifdef CONV_CTRL_OVERLAP_EN
          else if (x_full || (in_hs && ld == LD_LAST)) state_nxt = COMPUTE;
`endif
          else state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ld        <= '0;
      pos       <= '0;
      tap       <= '0;
      en_acc    <= 1'b0;
      clear_acc <= 1'b0;
      last_d1   <= 1'b0;
      load_out  <= 1'b0;
      m_valid_y <= 1'b0;
`ifdef CONV_CTRL_OVERLAP_EN
      x_full    <= 1'b0;
`endif
    end else begin
      // Read data arrives one cycle after issue, so the MAC strobes trail by one.
      en_acc    <= issue;
      clear_acc <= issue && (tap == '0);
      last_d1   <= issue && (tap == TAP_LAST);
      load_out  <= last_d1;

      if (load_out)  m_valid_y <= 1'b1;
      else if (y_hs) m_valid_y <= 1'b0;

      if (in_hs) begin
        if (ld == LD_LAST) begin
          ld <= '0;
`ifdef CONV_CTRL_OVERLAP_EN
          if (state == OUT) x_full <= 1'b1;
`endif
        end else begin
          ld <= ld + 1'b1;
        end
      end

      if (issue) tap <= (tap == TAP_LAST) ? '0 : tap + 1'b1;

      if (state == LOAD && state_nxt == COMPUTE) begin
        pos <= '0;
        tap <= '0;
      end

      if (state == OUT && y_hs) begin
        if (pos != POS_LAST) begin
          pos <= pos + 1'b1;
        end else begin
          pos <= '0;
`ifdef CONV_CTRL_OVERLAP_EN
          x_full <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_ctrl_30_9_11_1.sv
// Directed bench for conv_ctrl_30_9_11_1: timing table for the first position plus corner sequences.
module tb_conv_ctrl_30_9_11_1;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid_x, s_ready_x, m_valid_y, m_ready_y, wr_en_x;
  logic [4:0] addr_x;
  logic [3:0] addr_f;
  logic       en_acc, clear_acc, load_out;

  int errors = 0;
  int checks = 0;

  conv_ctrl_30_9_11_1 dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
    .wr_en_x(wr_en_x), .addr_x(addr_x), .addr_f(addr_f),
    .en_acc(en_acc), .clear_acc(clear_acc), .load_out(load_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sv, mr;
    logic       srdy, wr, en, clr, lo, mv;
    logic [4:0] ax;
    logic [3:0] af;
  } vec_t;

  vec_t tbl[43];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; s_valid_x = 1'b0; m_ready_y = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Full-rate vector starting from a fresh LOAD; reset is released on the first cycle.
  task automatic full_vector(input string tag);
    int hs = 0;
    for (int c = 0; c < 294; c++) begin
      @(posedge clk); #1;
      reset = 1'b1; s_valid_x = 1'b1; m_ready_y = 1'b1;
      @(negedge clk);
      if (c < 30) begin
        chk({tag, ".wr"}, wr_en_x, 1'b1);
        chk({tag, ".ld_addr"}, addr_x, c);
      end
      if (c == 0) begin
        chk({tag, ".mv0"}, m_valid_y, 1'b0);
        chk({tag, ".en0"}, en_acc, 1'b0);
      end
      if (c == 282) chk({tag, ".p21_first"}, addr_x, 21);
      if (m_valid_y && m_ready_y) hs++;
    end
    chk({tag, ".outputs"}, hs, 22);
  endtask

  initial begin
    int hs;
    int cnt;
    logic [4:0] exp_ax;

    reset = 1'b0; s_valid_x = 1'b0; m_ready_y = 1'b0;

    // Expected cycle-by-cycle behaviour from first load through the start of position 1.
    for (int c = 0; c < 43; c++) begin
      tbl[c] = '{sv: 1'b1, mr: 1'b1, srdy: 1'b0, wr: 1'b0, en: 1'b0, clr: 1'b0,
                 lo: 1'b0, mv: 1'b0, ax: 5'd0, af: 4'd0};
      if (c < 30) begin
        tbl[c].srdy = 1'b1; tbl[c].wr = 1'b1; tbl[c].ax = 5'(c);
      end else if (c < 39) begin
        tbl[c].ax = 5'(c - 30); tbl[c].af = 4'(c - 30);
      end
      if (c >= 31 && c <= 39) tbl[c].en = 1'b1;
      if (c == 31) tbl[c].clr = 1'b1;
      if (c == 40) tbl[c].lo = 1'b1;
      if (c == 41) tbl[c].mv = 1'b1;
      if (c == 42) tbl[c].ax = 5'd1;
    end

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst.s_ready_x", s_ready_x, 1'b1);
    chk("rst.m_valid_y", m_valid_y, 1'b0);
    chk("rst.en_acc", en_acc, 1'b0);
    chk("rst.clear_acc", clear_acc, 1'b0);
    chk("rst.load_out", load_out, 1'b0);
    chk("rst.addr_x", addr_x, 0);
    chk("rst.addr_f", addr_f, 0);

    // Full-rate vector: table-driven first 43 cycles
    hs = 0;
    for (int c = 0; c < 43; c++) begin
      @(posedge clk); #1;
      s_valid_x = tbl[c].sv; m_ready_y = tbl[c].mr;
      @(negedge clk);
      chk($sformatf("tbl[%0d].s_ready_x", c), s_ready_x, tbl[c].srdy);
      chk($sformatf("tbl[%0d].wr_en_x", c), wr_en_x, tbl[c].wr);
      chk($sformatf("tbl[%0d].en_acc", c), en_acc, tbl[c].en);
      chk($sformatf("tbl[%0d].clear_acc", c), clear_acc, tbl[c].clr);
      chk($sformatf("tbl[%0d].load_out", c), load_out, tbl[c].lo);
      chk($sformatf("tbl[%0d].m_valid_y", c), m_valid_y, tbl[c].mv);
      chk($sformatf("tbl[%0d].addr_x", c), addr_x, tbl[c].ax);
      chk($sformatf("tbl[%0d].addr_f", c), addr_f, tbl[c].af);
      if (m_valid_y && m_ready_y) hs++;
    end
    // Rest of the vector at full rate
    for (int c = 43; c < 295; c++) begin
      @(posedge clk); #1;
      s_valid_x = 1'b1; m_ready_y = 1'b1;
      @(negedge clk);
      if (c == 282) begin
        chk("full.p21_addr_x_first", addr_x, 21);
        chk("full.p21_addr_f_first", addr_f, 0);
      end
      if (c == 290) begin
        chk("full.p21_addr_x_last", addr_x, 29);
        chk("full.p21_addr_f_last", addr_f, 8);
      end
      if (c == 293) chk("full.last_mv", m_valid_y, 1'b1);
      if (c == 294) begin
`ifdef CONV_CTRL_OVERLAP_EN
        exp_ax = 5'd2;
`else
        exp_ax = 5'd0;
`endif
        chk("full.reload_ready", s_ready_x, 1'b1);
        chk("full.reload_addr", addr_x, exp_ax);
        chk("full.reload_mv", m_valid_y, 1'b0);
      end
      if (c < 294 && m_valid_y && m_ready_y) hs++;
    end
    chk("full.outputs", hs, 22);

    // Backpressure at output 3 (t0 = 66, m_valid_y from 77)
    do_reset();
    for (int c = 0; c < 85; c++) begin
      @(posedge clk); #1;
      s_valid_x = 1'b1; m_ready_y = !(c >= 77 && c <= 81);
      @(negedge clk);
      if (c >= 77 && c <= 81) begin
        chk($sformatf("bp[%0d].m_valid_y", c), m_valid_y, 1'b1);
        chk($sformatf("bp[%0d].en_acc", c), en_acc, 1'b0);
        chk($sformatf("bp[%0d].addr_x", c), addr_x, 0);
        chk($sformatf("bp[%0d].load_out", c), load_out, 1'b0);
      end
      if (c == 82) chk("bp.hs_mv", m_valid_y, 1'b1);
      if (c == 83) begin
        chk("bp.p4_addr_x", addr_x, 4);
        chk("bp.p4_addr_f", addr_f, 0);
        chk("bp.p4_mv", m_valid_y, 1'b0);
      end
      if (c == 84) begin
        chk("bp.p4_en", en_acc, 1'b1);
        chk("bp.p4_clr", clear_acc, 1'b1);
      end
    end

    // Input gaps: s_valid_x pattern 1,0,0,1
    do_reset();
    cnt = 0;
    for (int c = 0; c < 62; c++) begin
      @(posedge clk); #1;
      s_valid_x = (c % 4 == 0) || (c % 4 == 3); m_ready_y = 1'b1;
      @(negedge clk);
      if (c <= 59) begin
        chk($sformatf("gap[%0d].s_ready_x", c), s_ready_x, 1'b1);
        chk($sformatf("gap[%0d].wr_en_x", c), wr_en_x, s_valid_x);
        chk($sformatf("gap[%0d].addr_x", c), addr_x, cnt);
        if (s_valid_x) cnt++;
      end
      if (c == 60) begin
        chk("gap.compute_ready", s_ready_x, 1'b0);
        chk("gap.compute_addr", addr_x, 0);
        chk("gap.compute_en", en_acc, 1'b0);
      end
      if (c == 61) begin
        chk("gap.first_en", en_acc, 1'b1);
        chk("gap.first_clr", clear_acc, 1'b1);
        chk("gap.k1_addr", addr_x, 1);
      end
    end
    chk("gap.samples", cnt, 30);

    // Reset in the middle of position 7 (t0 = 114), then a clean vector
    do_reset();
    for (int c = 0; c < 118; c++) begin
      @(posedge clk); #1;
      s_valid_x = 1'b1; m_ready_y = 1'b1;
      if (c == 117) reset = 1'b0;
      @(negedge clk);
      if (c == 114) chk("midrst.p7_addr", addr_x, 7);
    end
    full_vector("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
